// File: rtl/cmd_start_arbiter.sv
// cmd_start_arbiter: shares one command sequencer between N_REQ start requesters.
// Requests are latched into a pending register, one is picked round-robin, and a
// single-cycle start pulse is issued. The arbiter then follows the sequencer's ready
// handshake through one full sequence and enforces a holdoff gap before the next start.

module cmd_start_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic                CMD_CLK,
  input  logic                CMD_RST,
  input  logic [N_REQ-1:0]    REQ,
  input  logic [N_REQ-1:0]    REQ_ENABLE,
  input  logic [15:0]         CONF_HOLDOFF,
  input  logic [15:0]         CONF_TIMEOUT,
  input  logic                CLEAR,
  input  logic                CMD_READY,
  output logic                CMD_START,
  output logic [N_REQ-1:0]    GRANT,
  output logic [ID_WIDTH-1:0] GRANT_ID,
  output logic [N_REQ-1:0]    PENDING,
  output logic                BUSY,
  output logic [15:0]         DROP_CNT,
  output logic                TIMEOUT_ERR
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitBusy = 2'd1,
    StWaitDone = 2'd2,
    StHoldoff  = 2'd3
  } state_e;

  localparam logic [ID_WIDTH-1:0] LastIdx = ID_WIDTH'(N_REQ - 1);

  // State and datapath registers
  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0]    pending_q, pending_d;
  logic                cmd_start_q, cmd_start_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic                timeout_err_q, timeout_err_d;
  logic [15:0]         tmo_cnt_q, tmo_cnt_d;
  logic [15:0]         conf_tmo_q, conf_tmo_d;
  logic [15:0]         hold_cnt_q, hold_cnt_d;

  // Selection signals
  logic [N_REQ-1:0]    eligible;
  logic                hi_valid, lo_valid;
  logic [ID_WIDTH-1:0] hi_idx, lo_idx;
  logic                sel_valid;
  logic [ID_WIDTH-1:0] sel_idx;
  logic [N_REQ-1:0]    sel_onehot;
  logic                issue;

  // Pending and drop bookkeeping
  logic [N_REQ-1:0]    arrive;
  logic [N_REQ-1:0]    granted;
  logic [N_REQ-1:0]    drop_vec;
  logic [3:0]          drop_num;
  logic [16:0]         drop_base;
  logic [16:0]         drop_sum;

  // FSM helpers
  logic                tmo_fire;
  logic [15:0]         tmo_inc;

  // Round-robin pick: lowest eligible index at or above the pointer, else lowest overall.
  // A requester whose enable is low is never picked, even if its pending bit is still set.
  always_comb begin
    eligible = pending_q & REQ_ENABLE;
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!hi_valid && eligible[k] && (ID_WIDTH'(k) >= ptr_q)) begin
        hi_valid = 1'b1;
        hi_idx   = ID_WIDTH'(k);
      end
      if (!lo_valid && eligible[k]) begin
        lo_valid = 1'b1;
        lo_idx   = ID_WIDTH'(k);
      end
    end
    sel_valid  = hi_valid | lo_valid;
    sel_idx    = hi_valid ? hi_idx : lo_idx;
    sel_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
  end

  // A start is issued only from idle with an idle sequencer and something to serve.
  assign issue = (state_q == StIdle) && CMD_READY && sel_valid;

  // Pending-bit update and saturating drop counter; a same-cycle drop beats CLEAR.
  always_comb begin
    arrive    = REQ & REQ_ENABLE;
    granted   = issue ? sel_onehot : '0;
    // A request arriving while its bit is granted re-arms the bit instead of being lost.
    drop_vec  = arrive & pending_q & ~granted;
    pending_d = REQ_ENABLE & ((pending_q & ~granted) | arrive);
    drop_num  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      drop_num = drop_num + {3'b000, drop_vec[k]};
    end
    drop_base  = CLEAR ? 17'd0 : {1'b0, drop_cnt_q};
    drop_sum   = drop_base + {13'd0, drop_num};
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Sequence FSM: start, wait for busy, wait for done, holdoff.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cmd_start_d = 1'b0;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    tmo_cnt_d   = tmo_cnt_q;
    conf_tmo_d  = conf_tmo_q;
    hold_cnt_d  = hold_cnt_q;
    tmo_fire    = 1'b0;
    tmo_inc     = tmo_cnt_q + 16'd1;

    unique case (state_q)
      StIdle: begin
        if (issue) begin
          cmd_start_d = 1'b1;
          grant_d     = sel_onehot;
          grant_id_d  = sel_idx;
          ptr_d       = (sel_idx == LastIdx) ? '0 : sel_idx + ID_WIDTH'(1);
          tmo_cnt_d   = '0;
          conf_tmo_d  = CONF_TIMEOUT;
          state_d     = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (!CMD_READY) begin
          state_d = StWaitDone;
        end else begin
          tmo_cnt_d = tmo_inc;
          // A zero limit disables the timeout; the counter is then free to wrap.
          if ((conf_tmo_q != 16'd0) && (tmo_inc == conf_tmo_q)) begin
            tmo_fire   = 1'b1;
            grant_d    = '0;
            hold_cnt_d = CONF_HOLDOFF;
            state_d    = (CONF_HOLDOFF == 16'd0) ? StIdle : StHoldoff;
          end
        end
      end
      StWaitDone: begin
        if (CMD_READY) begin
          grant_d    = '0;
          hold_cnt_d = CONF_HOLDOFF;
          state_d    = (CONF_HOLDOFF == 16'd0) ? StIdle : StHoldoff;
        end
      end
      StHoldoff: begin
        // Loaded with the holdoff length on entry, so this state lasts exactly that long.
        if (hold_cnt_q <= 16'd1) begin
          state_d = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    timeout_err_d = tmo_fire | (timeout_err_q & ~CLEAR);
  end

  // Register update with synchronous active-high reset.
  always_ff @(posedge CMD_CLK) begin
    if (CMD_RST) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      pending_q     <= '0;
      cmd_start_q   <= 1'b0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      drop_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
      conf_tmo_q    <= '0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      pending_q     <= pending_d;
      cmd_start_q   <= cmd_start_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      drop_cnt_q    <= drop_cnt_d;
      timeout_err_q <= timeout_err_d;
      tmo_cnt_q     <= tmo_cnt_d;
      conf_tmo_q    <= conf_tmo_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign CMD_START   = cmd_start_q;
  assign GRANT       = grant_q;
  assign GRANT_ID    = grant_id_q;
  assign PENDING     = pending_q;
  assign BUSY        = (state_q != StIdle);
  assign DROP_CNT    = drop_cnt_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule
